// File: rtl/ecu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ecu_scheduler
// Brief    : Round-robin sharing of one ECU/AES engine between NUM_REQ
//            requesters. Latches the winner's operands, strobes the ECU,
//            waits for completion and returns the result with a done pulse.
// Option   : define ECU_SCHEDULER_TIMEOUT_EN to add a BUSY watchdog that
//            aborts after TIMEOUT_CYCLES and raises sticky timeout_err.
// Revision : 1.0 - initial release
// ============================================================================
module ecu_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_ed_sel,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [127:0]           resp_data,
  output logic                   busy,
  output logic                   ecu_start_op,
  output logic                   ecu_ed_sel,
  output logic [127:0]           ecu_data_in,
  output logic [127:0]           ecu_key_in,
  input  logic                   ecu_en_done,
  input  logic [127:0]           ecu_result
`ifdef ECU_SCHEDULER_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GRANT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [127:0]     lat_data;
  logic [127:0]     lat_key;
  logic             lat_ed_sel;

  logic             hi_valid;
  logic             lo_valid;
  logic [PTR_W-1:0] hi_idx;
  logic [PTR_W-1:0] lo_idx;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;

  logic [127:0]     sel_data;
  logic [127:0]     sel_key;
  logic             sel_ed_sel;

`ifdef ECU_SCHEDULER_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
`else
  // Watchdog not built: TIMEOUT_CYCLES has no effect in this configuration.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  // Round-robin search: lowest requester at or above rr_ptr, else wrap to lowest overall.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_valid = 1'b1;
        lo_idx   = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr) begin
          hi_valid = 1'b1;
          hi_idx   = PTR_W'(i);
        end
      end
    end
  end

  assign pick_valid = lo_valid;
  assign pick_idx   = hi_valid ? hi_idx : lo_idx;

  // Operand mux selecting the candidate winner's data, key and mode slices.
  always_comb begin
    sel_data   = '0;
    sel_key    = '0;
    sel_ed_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == pick_idx) begin
        sel_data   = req_data[128*i +: 128];
        sel_key    = req_key[128*i +: 128];
        sel_ed_sel = req_ed_sel[i];
      end
    end
  end

  // Scheduler sequencing: arbitrate, issue, wait for the ECU, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      winner     <= '0;
      grant      <= '0;
      resp_data  <= '0;
      lat_data   <= '0;
      lat_key    <= '0;
      lat_ed_sel <= 1'b0;
`ifdef ECU_SCHEDULER_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            winner     <= pick_idx;
            grant      <= GRANT_LSB << pick_idx;
            lat_data   <= sel_data;
            lat_key    <= sel_key;
            lat_ed_sel <= sel_ed_sel;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef ECU_SCHEDULER_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (ecu_en_done) begin
            resp_data <= ecu_result;
            state     <= ST_RESP;
          end
`ifdef ECU_SCHEDULER_TIMEOUT_EN
          else if (to_cnt == TO_LIMIT) begin
            // Engine never answered: return an all-ones block and flag it.
            resp_data   <= '1;
            timeout_err <= 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          grant  <= '0;
          rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state != ST_IDLE);
  assign ecu_start_op = (state == ST_ISSUE);
  assign done         = (state == ST_RESP) ? grant : '0;
  assign ecu_data_in  = lat_data;
  assign ecu_key_in   = lat_key;
  assign ecu_ed_sel   = lat_ed_sel;

endmodule
`default_nettype wire

// File: tb/tb_ecu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecu_scheduler
// Brief    : Vector table, directed corner sequences and a randomized run
//            checked against a transaction-level round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecu_scheduler;

  localparam int N = 2;

  localparam logic [127:0] D0 = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] K0 = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] R0 = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] R1 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req, req_ed_sel, grant, done;
  logic [N*128-1:0] req_data, req_key;
  logic [127:0]     resp_data, ecu_data_in, ecu_key_in, ecu_result;
  logic             busy, ecu_start_op, ecu_ed_sel, ecu_en_done;
`ifdef ECU_SCHEDULER_TIMEOUT_EN
  logic             timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecu_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ed_sel(req_ed_sel),
    .req_data(req_data), .req_key(req_key), .grant(grant), .done(done),
    .resp_data(resp_data), .busy(busy), .ecu_start_op(ecu_start_op),
    .ecu_ed_sel(ecu_ed_sel), .ecu_data_in(ecu_data_in), .ecu_key_in(ecu_key_in),
    .ecu_en_done(ecu_en_done), .ecu_result(ecu_result)
`ifdef ECU_SCHEDULER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct {
    logic [N-1:0] rq;
    logic [N-1:0] ed;
    int           lat;
    logic [127:0] res;
    logic [N-1:0] xg;
    logic [127:0] xd;
    logic [127:0] xk;
    logic         xm;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in ECU transform used by the randomized phase.
  function automatic logic [127:0] ecu_func(input logic [127:0] d, input logic [127:0] k, input logic m);
    return m ? (d ^ k) : ({d[63:0], d[127:64]} ^ ~k);
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One-cycle reset ending at a negedge with the DUT in IDLE; checks reset outputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    ecu_en_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_grant", grant, '0);
    chk("rst_done", done, '0);
    chk("rst_busy", busy, 0);
    chk("rst_start", ecu_start_op, 0);
    chk("rst_resp", resp_data, '0);
    chk("rst_data_in", ecu_data_in, '0);
    chk("rst_key_in", ecu_key_in, '0);
    chk("rst_ed_sel", ecu_ed_sel, 0);
`ifdef ECU_SCHEDULER_TIMEOUT_EN
    chk("rst_timeout_err", timeout_err, 0);
`endif
  endtask

  // Called at an IDLE negedge with req already driven: the next cycle must be ISSUE.
  task automatic check_issue(input logic [N-1:0] g, input logic [127:0] d,
                             input logic [127:0] k, input logic m);
    @(negedge clk);
    chk("issue_start", ecu_start_op, 1);
    chk("issue_busy", busy, 1);
    chk("issue_grant", grant, g);
    chk("issue_data", ecu_data_in, d);
    chk("issue_key", ecu_key_in, k);
    chk("issue_mode", ecu_ed_sel, m);
  endtask

  // ECU answers after lat BUSY cycles; done must follow one cycle later.
  task automatic finish_op(input int lat, input logic [127:0] res,
                           input logic [N-1:0] g, input bit drop);
    int early;
    early = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (done !== '0 || ecu_start_op !== 1'b0 || busy !== 1'b1) early++;
      if (i == lat) begin
        ecu_en_done = 1'b1;
        ecu_result  = res;
      end
    end
    @(negedge clk);
    ecu_en_done = 1'b0;
    ecu_result  = rand128();
    chk("busy_quiet", early, 0);
    chk("done_pulse", done, g);
    chk("resp_data", resp_data, res);
    chk("resp_busy", busy, 1);
    if (drop) req = '0;
    @(negedge clk);
    chk("post_done", done, '0);
    chk("post_busy", busy, 0);
    chk("post_grant", grant, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] keep;
    logic [N-1:0] rnd_bits;
    int           ptr, exp_w, cnt, n;
    bit           exp_start, exp_done, m_busy, was_idle, got;
    logic [127:0] exp_d, exp_k, exp_res;
    logic         exp_m;

    rst = 1'b1; req = '0; req_ed_sel = '0; req_data = '0; req_key = '0;
    ecu_en_done = 1'b0; ecu_result = '0;

    vt[0] = '{2'b01, 2'b01, 12, R0,       2'b01, D0, K0, 1'b1};
    vt[1] = '{2'b10, 2'b00,  3, R1,       2'b10, D1, K1, 1'b0};
    vt[2] = '{2'b11, 2'b10,  1, ~R0,      2'b01, D0, K0, 1'b0};
    vt[3] = '{2'b11, 2'b10,  2, ~R1,      2'b10, D1, K1, 1'b1};
    vt[4] = '{2'b10, 2'b11,  5, R0 ^ R1,  2'b10, D1, K1, 1'b1};
    vt[5] = '{2'b01, 2'b00,  4, 128'h0,   2'b01, D0, K0, 1'b0};

    // Vector table, starting from reset (rr_ptr = 0).
    do_reset();
    for (int v = 0; v < 6; v++) begin
      req = vt[v].rq; req_ed_sel = vt[v].ed;
      req_data = {D1, D0}; req_key = {K1, K0};
      check_issue(vt[v].xg, vt[v].xd, vt[v].xk, vt[v].xm);
      finish_op(vt[v].lat, vt[v].res, vt[v].xg, 1'b1);
    end

    // Contention from reset with both requests held: 01, 10, 01, 10.
    do_reset();
    req = 2'b11; req_ed_sel = 2'b10; req_data = {D1, D0}; req_key = {K1, K0};
    for (int op = 0; op < 4; op++) begin
      if (op % 2 == 0) begin
        check_issue(2'b01, D0, K0, 1'b0);
        finish_op(2 + op, R0 ^ 128'(op), 2'b01, 1'b0);
      end else begin
        check_issue(2'b10, D1, K1, 1'b1);
        finish_op(2 + op, R1 ^ 128'(op), 2'b10, op == 3);
      end
    end

    // Operand change after latching must not reach the ECU.
    req = 2'b01; req_ed_sel = 2'b01; req_data = {D1, D0};
    check_issue(2'b01, D0, K0, 1'b1);
    @(negedge clk);
    req_data[127:0] = '0; req_key[127:0] = '0; req_ed_sel = '0;
    @(negedge clk);
    chk("hold_data", ecu_data_in, D0);
    chk("hold_key", ecu_key_in, K0);
    chk("hold_mode", ecu_ed_sel, 1);
    finish_op(3, R0, 2'b01, 1'b1);

    // Stray completion while idle.
    keep = resp_data;
    ecu_en_done = 1'b1; ecu_result = rand128();
    @(negedge clk);
    ecu_en_done = 1'b0;
    @(negedge clk);
    chk("stray_done", done, '0);
    chk("stray_busy", busy, 0);
    chk("stray_start", ecu_start_op, 0);
    chk("stray_resp", resp_data, keep);

    // Reset in BUSY with rr_ptr = 1: next contention must start at requester 0.
    req_data = {D1, D0}; req_key = {K1, K0}; req_ed_sel = 2'b00;
    req = 2'b01;
    check_issue(2'b01, D0, K0, 1'b0);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    do_reset();
    req = 2'b11;
    check_issue(2'b01, D0, K0, 1'b0);
    finish_op(2, R1, 2'b01, 1'b1);
    do_reset();
    req = 2'b10;
    check_issue(2'b10, D1, K1, 1'b0);
    finish_op(2, R0, 2'b10, 1'b1);

`ifdef ECU_SCHEDULER_TIMEOUT_EN
    // ECU never answers: watchdog aborts 64 cycles after entering BUSY.
    do_reset();
    req = 2'b01;
    check_issue(2'b01, D0, K0, 1'b0);
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (done !== '0) got = 1'b1;
    end
    chk("to_cycles", n, 65);
    chk("to_done", done, 2'b01);
    chk("to_resp", resp_data, {128{1'b1}});
    chk("to_err", timeout_err, 1);
    req = '0;
    repeat (5) @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    do_reset();
`endif

    // Randomized run against the transaction-level model.
    do_reset();
    ptr = 0; exp_w = 0; cnt = 0;
    exp_start = 1'b0; exp_done = 1'b0; m_busy = 1'b0;
    exp_d = '0; exp_k = '0; exp_m = 1'b0; exp_res = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_start", ecu_start_op, exp_start);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_done", done, exp_done ? onehot(exp_w) : '0);
      if (exp_done) chk("rnd_resp", resp_data, exp_res);
      if (exp_start) begin
        exp_w   = rr_pick(req, ptr);
        exp_d   = req_data[128*exp_w +: 128];
        exp_k   = req_key[128*exp_w +: 128];
        exp_m   = req_ed_sel[exp_w];
        exp_res = ecu_func(exp_d, exp_k, exp_m);
      end
      if (m_busy) begin
        chk("rnd_grant", grant, onehot(exp_w));
        chk("rnd_data_in", ecu_data_in, exp_d);
        chk("rnd_key_in", ecu_key_in, exp_k);
        chk("rnd_mode", ecu_ed_sel, exp_m);
      end

      was_idle    = !m_busy;
      ecu_en_done = 1'b0;
      ecu_result  = rand128();
      if (exp_done) begin
        ptr = (exp_w + 1) % N;
        req[exp_w] = 1'b0;
        exp_done = 1'b0;
        m_busy   = 1'b0;
      end else if (exp_start) begin
        cnt = $urandom_range(1, 6);
        exp_start = 1'b0;
      end else if (m_busy) begin
        cnt--;
        if (cnt == 0) begin
          ecu_en_done = 1'b1;
          ecu_result  = ecu_func(ecu_data_in, ecu_key_in, ecu_ed_sel);
          exp_done    = 1'b1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        ecu_en_done = 1'b1;
      end

      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[128*i +: 128] = rand128();
          req_key[128*i +: 128]  = rand128();
          rnd_bits = N'($urandom);
          req_ed_sel[i] = rnd_bits[0];
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        req_data   = {rand128(), rand128()};
        rnd_bits   = N'($urandom);
        req_ed_sel = rnd_bits;
      end

      if (was_idle && req != '0) begin
        exp_start = 1'b1;
        m_busy    = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecu_scheduler.md
Name: ecu_scheduler

Overview:
- Shares one ECU (encryption control unit plus its AES engine) between NUM_REQ independent requesters, e.g. the host data path and the key-management path.
- Arbitrates round-robin and latches the winner's data, key and mode.
- Issues a one-cycle start to the ECU, waits for en_done, captures the result and returns it to the winner with a one-cycle done pulse.
- Sits between the bus/request front-end and the ECU.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 64, maximum cycles in BUSY before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until that requester's done.
- req_ed_sel  in  NUM_REQ  per-requester mode: 1 = encrypt, 0 = decrypt.
- req_data  in  NUM_REQ*128  per-requester data block; slice i = bits [128*i+127:128*i].
- req_key  in  NUM_REQ*128  per-requester key; same slicing.
- grant  out  NUM_REQ  one-hot, identifies the requester being served, from ISSUE through RESP.
- done  out  NUM_REQ  one-cycle pulse to the served requester.
- resp_data  out  128  result; valid while done is high, held until the next capture.
- busy  out  1  high in every state except IDLE.
- ecu_start_op  out  1  one-cycle start strobe to the ECU.
- ecu_ed_sel  out  1  latched mode.
- ecu_data_in  out  128  latched data.
- ecu_key_in  out  128  latched key.
- ecu_en_done  in  1  ECU completion pulse.
- ecu_result  in  128  ECU output block; valid in the cycle ecu_en_done is high.

Behaviour:
- States: IDLE, ISSUE, BUSY, RESP.
- Reset values: all outputs 0, rr_ptr = 0, state = IDLE, latch registers = 0. Reset is synchronous. Reset asserted in any state returns to IDLE on the next edge with no done pulse. The ECU is reset by its own reset.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr with wrap-around.
  - Latch that requester's data, key and ed_sel; set grant to its one-hot code; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: ecu_start_op = 1 for exactly one cycle; go to BUSY. ecu_data_in, ecu_key_in and ecu_ed_sel come from the latch and stay stable from ISSUE through RESP.
- BUSY:
  - Wait for ecu_en_done. On the cycle it is high, capture ecu_result into resp_data and go to RESP.
  - ecu_en_done in IDLE or ISSUE is ignored.
- RESP:
  - done[winner] = 1 for one cycle; then grant goes to 0.
  - rr_ptr = winner + 1 modulo NUM_REQ; go to IDLE.
- Latency: req sampled at edge 0 → ecu_start_op high in cycle 1 → done exactly one cycle after the cycle in which ecu_en_done is seen.
- Back-to-back: minimum 4 cycles between two ecu_start_op pulses (the IDLE cycle is never skipped).
- A requester that still holds req in the cycle after its done is treated as a new request and competes normally. It can win again only if no other requester is waiting.
- Input changes (req_data, req_key, req_ed_sel) after latching have no effect on the operation in flight.
- If req[winner] drops during BUSY, the operation still completes and done still pulses; the requester ignores it.
- Simultaneous requests: round-robin guarantees each waiting requester is served within NUM_REQ operations.

Optional Feature:
- Macro: ECU_SCHEDULER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears in ISSUE and increments in BUSY.
  - If it reaches TIMEOUT_CYCLES without ecu_en_done: go to RESP with resp_data = all ones, done pulses, and the sticky output timeout_err (1 bit, added port) goes high.
  - timeout_err clears only on reset.
- Undefined: no counter and no timeout_err port; BUSY waits indefinitely.

Test Plan:
- Single encrypt:
  - Stimulus: req = 01, data0 = 54776F204F6E65204E696E652054776F, key0 = 5468617473206D79204B756E67204675, ed_sel0 = 1; ECU model asserts en_done 12 cycles after start with result 29C3505F571420F6402299B31A02D73A.
  - Required: ecu_start_op pulses once in the cycle after req; done = 01 for one cycle; resp_data = 29C3…D73A; busy returns to 0 one cycle later.
- Contention: req = 11 asserted in the same cycle from reset, both held. Required: grant order 01, 10, 01, 10; each ecu_start_op carries the matching data/key slice.
- Data change after latch: change data0 to 0 during BUSY. Required: ecu_data_in still 54776F20…; the result is unchanged.
- Stray done: ecu_en_done pulsed while in IDLE. Required: no done pulse and no state change; busy stays 0.
- Mid-operation reset: rst asserted for 1 cycle while in BUSY. Required: the next cycle shows all outputs 0 and state IDLE; a subsequent req = 10 is granted to requester 1 first because rr_ptr = 0 after reset and req0 is absent.
- Timeout (with ECU_SCHEDULER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 64): ecu_en_done is never asserted. Required: done pulses 64 cycles after entering BUSY; resp_data = FFFF…FF; timeout_err = 1 and stays 1 until rst.
